boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 113 +++++++++++
 tb/tb_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - serial boot loader: framed byte stream into instruction memory
// Frame: SYNC, N[15:8], N[7:0], 4*N big-endian data bytes, XOR checksum of the data bytes.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_wren,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_csum;
  logic        r_wren;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_len_too_big;
  logic        w_last_byte;
  logic        w_last_word;

  assign rx_ready      = (r_state != DONE) && (r_state != ERROR);
  assign cpu_hold      = (r_state != DONE);
  assign done          = (r_state == DONE);
  assign error         = (r_state == ERROR);
  assign imem_wren     = r_wren;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;

  assign w_accept      = rx_valid && rx_ready;
  assign w_len_full    = {r_len[15:8], rx_data};
  assign w_len_too_big = ({16'd0, w_len_full} > 32'(MAX_WORDS));
  assign w_last_byte   = (r_byte_cnt == 2'd3);
  assign w_last_word   = (r_word_cnt == r_len - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && (rx_data == SYNC_BYTE)) w_next = LEN_HI;
      LEN_HI:  if (w_accept) w_next = LEN_LO;
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_full == 16'd0) w_next = CHECK;
          else if (w_len_too_big)  w_next = ERROR;
          else                     w_next = DATA;
        end
      end
      DATA:    if (w_accept && w_last_byte && w_last_word) w_next = CHECK;
      CHECK:   if (w_accept) w_next = (rx_data == r_csum) ? DONE : ERROR;
      DONE:    w_next = DONE;
      ERROR:   w_next = ERROR;
      default: w_next = IDLE;
    endcase
  end

  // Write strobe is a registered one-cycle pulse; address/data hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_csum     <= 8'd0;
      r_wren     <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'd0;
    end else begin
      r_wren <= 1'b0;
      if (w_accept) begin
        case (r_state)
          LEN_HI: r_len[15:8] <= rx_data;
          LEN_LO: r_len[7:0]  <= rx_data;
          DATA: begin
            r_shift    <= {r_shift[15:0], rx_data};
            r_csum     <= r_csum ^ rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_wren     <= 1'b1;
              r_wdata    <= {r_shift, rx_data};
              r_addr     <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
              r_word_cnt <= r_word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader against a frame-level model
module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_wren;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_wren  (imem_wren),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_result;

  always @(posedge clk) begin
    #1;
    if (imem_wren === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result: 0 = still waiting, 1 = done, 2 = error.
  task automatic model_frame();
    int s;
    int n;
    logic [7:0] cs;
    exp_addr.delete();
    exp_data.delete();
    exp_result = 0;
    s = -1;
    for (int i = 0; i < frame.size(); i++)
      if (s < 0 && frame[i] == SYNC) s = i;
    if (s < 0 || s + 2 >= frame.size()) return;
    n = int'(frame[s+1]) * 256 + int'(frame[s+2]);
    if (n > MAXW) begin
      exp_result = 2;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      int b;
      b = s + 3 + 4 * k;
      if (b + 3 >= frame.size()) return;
      exp_addr.push_back(BASE + 32'(4 * k));
      exp_data.push_back({frame[b], frame[b+1], frame[b+2], frame[b+3]});
      cs = cs ^ frame[b] ^ frame[b+1] ^ frame[b+2] ^ frame[b+3];
    end
    if (s + 3 + 4 * n < frame.size())
      exp_result = (frame[s + 3 + 4 * n] == cs) ? 1 : 2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int rnd);
    if (rnd != 0) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".wren"},  imem_wren,  1'b0);
    check({tag, ".addr"},  imem_addr,  BASE);
    check({tag, ".wdata"}, imem_wdata, 32'd0);
    check({tag, ".ready"}, rx_ready,   1'b1);
    check({tag, ".hold"},  cpu_hold,   1'b1);
    check({tag, ".done"},  done,       1'b0);
    check({tag, ".error"}, error,      1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state(tag);
    rst = 1'b1;
    @(negedge clk);
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic run_and_check(input string tag, input int rnd);
    model_frame();
    got_addr.delete();
    got_data.delete();
    foreach (frame[i]) send_byte(frame[i], rnd);
    repeat (3) @(negedge clk);
    check({tag, ".nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        check($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
        check($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
      end
    end
    if (exp_addr.size() > 0) begin
      check({tag, ".addr_hold"},  imem_addr,  exp_addr[exp_addr.size()-1]);
      check({tag, ".wdata_hold"}, imem_wdata, exp_data[exp_data.size()-1]);
    end
    check({tag, ".done"},  done,     exp_result == 1);
    check({tag, ".error"}, error,    exp_result == 2);
    check({tag, ".hold"},  cpu_hold, exp_result != 1);
    check({tag, ".ready"}, rx_ready, exp_result == 0);
  endtask

  task automatic base_frame();
    frame = '{8'h00, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  initial begin
    logic [7:0] cs;
    int n;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    base_frame();
    frame.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
    run_and_check("good", 0);
    check("good.w0", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h1234_5678);
    check("good.w1", (got_data.size() > 1) ? got_data[1] : 32'hx, 32'h9ABC_DEF0);
    check("good.a1", (got_addr.size() > 1) ? got_addr[1] : 32'hx, BASE + 32'd4);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    got_addr.delete();
    foreach (frame[i]) send_byte(frame[i], 0);
    repeat (2) @(negedge clk);
    check("done_terminal.nwr", 32'(got_addr.size()), 32'd0);
    check("done_terminal.done", done, 1'b1);

    do_reset("rst1");
    base_frame();
    frame.push_back(8'h08);
    run_and_check("badcs08", 0);
    do_reset("rst2");
    base_frame();
    frame.push_back(8'h09);
    run_and_check("badcs09", 0);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    got_addr.delete();
    foreach (frame[i]) send_byte(frame[i], 0);
    repeat (2) @(negedge clk);
    check("err_terminal.error", error, 1'b1);
    check("err_terminal.done",  done,  1'b0);

    do_reset("rst3");
    frame = '{8'hA5, 8'h01, 8'h01};
    run_and_check("oversize", 0);

    do_reset("rst4");
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_and_check("zero_len", 0);

    do_reset("rst5");
    base_frame();
    frame.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
    run_and_check("gappy", 1);

    do_reset("rst6");
    base_frame();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    check("midrst.nwr", 32'(got_addr.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    frame = '{8'h00, 8'h02, 8'h12, 8'h34};
    run_and_check("nosync", 0);
    base_frame();
    frame.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
    run_and_check("resend", 0);

    do_reset("rst7");
    frame = '{8'hA5, 8'h01, 8'h00};
    cs = 8'h00;
    for (int i = 0; i < 4 * MAXW; i++) begin
      frame.push_back(8'($urandom));
      cs ^= frame[frame.size()-1];
    end
    frame.push_back(cs);
    run_and_check("max_len", 0);

    for (int t = 0; t < 12; t++) begin
      do_reset($sformatf("rrst%0d", t));
      frame.delete();
      repeat ($urandom_range(0, 3)) begin
        cs = 8'($urandom);
        frame.push_back((cs == SYNC) ? 8'h00 : cs);
      end
      frame.push_back(SYNC);
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(0, 6));
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      if (n <= MAXW) begin
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          frame.push_back(8'($urandom));
          cs ^= frame[frame.size()-1];
        end
        frame.push_back(($urandom_range(0, 2) == 0) ? cs ^ 8'(1 << $urandom_range(0, 7)) : cs);
      end
      run_and_check($sformatf("rand%0d", t), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
